// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared enums, flag indices and command classifiers for alu_sequencer
package alu_seq_pkg;

   // ALU command encoding (identical to the ALU's own decode)
   typedef enum logic [3:0] {
      CMD_AND = 4'b0000,
      CMD_EOR = 4'b0001,
      CMD_SUB = 4'b0010,
      CMD_RSB = 4'b0011,
      CMD_ADD = 4'b0100,
      CMD_ADC = 4'b0101,
      CMD_SBC = 4'b0110,
      CMD_RSC = 4'b0111,
      CMD_TST = 4'b1000,
      CMD_TEQ = 4'b1001,
      CMD_CMP = 4'b1010,
      CMD_CMN = 4'b1011,
      CMD_ORR = 4'b1100,
      CMD_MOV = 4'b1101,
      CMD_BIC = 4'b1110,
      CMD_MVN = 4'b1111
   } alu_cmd_e;

   // ARM condition field encoding
   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_EXEC   = 2'b01,
      ST_RESULT = 2'b10
   } state_e;

   // Bit positions inside the NZCV nibble
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   // Arithmetic ops produce all four flags from the adder
   function automatic logic is_arith(input logic [3:0] cmd);
      return cmd inside {CMD_SUB, CMD_RSB, CMD_ADD, CMD_ADC,
                         CMD_SBC, CMD_RSC, CMD_CMP, CMD_CMN};
   endfunction

   // Compare/test ops set flags only and never write back
   function automatic logic is_test(input logic [3:0] cmd);
      return cmd inside {CMD_TST, CMD_TEQ, CMD_CMP, CMD_CMN};
   endfunction

endpackage

// File: rtl/alu_sequencer_cond_check.sv
// rtl/alu_sequencer_cond_check.sv - combinational ARM condition-code evaluator
module cond_check
   import alu_seq_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n;
   logic z;
   logic c;
   logic v;

   assign n = nzcv[FLAG_N];
   assign z = nzcv[FLAG_Z];
   assign c = nzcv[FLAG_C];
   assign v = nzcv[FLAG_V];

   // Decode the condition field against the current flags
   always_comb begin
      pass = 1'b0;
      case (cond_e'(cond))
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - ALU issue/commit sequencer and NZCV owner; ALU_SEQ_CONDEXEC_EN enables conditional execution
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RD_W   = 4
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_cond,
   input  logic [3:0]        req_cmd,
   input  logic              req_set_flags,
   input  logic [RD_W-1:0]   req_rd,
   input  logic [DATA_W-1:0] req_src1,
   input  logic [DATA_W-1:0] req_src2,
   input  logic              req_shift_carry,
   input  logic              req_was_shifted,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   output logic [3:0]        alu_cmd,
   output logic              alu_shift_carry,
   output logic              alu_was_shifted,
   output logic [3:0]        alu_flags,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_nzcv,
   output logic [3:0]        flags,
   output logic              wb_valid,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_data
);

   state_e            state;
   state_e            state_nx;
   logic              cond_pass;
   logic              issue;
   logic              commit;
   logic [RD_W-1:0]   rd_q;
   logic              set_flags_q;
   logic [3:0]        flags_nx;
   logic              upd_flags;
   logic              do_wb;

`ifdef ALU_SEQ_CONDEXEC_EN
   cond_check u_cond_check (
      .cond (req_cond),
      .nzcv (flags),
      .pass (cond_pass)
   );
`else
   // Without conditional execution every op behaves as AL
   logic unused_cond;
   assign unused_cond = ^req_cond;
   assign cond_pass   = 1'b1;
`endif

   // The ALU always sees the architectural flags (ADC/SBC/RSC carry-in)
   assign alu_flags = flags;

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state: a failed condition is consumed in place, a passing one runs EXEC then RESULT
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (req_valid && cond_pass) state_nx = ST_EXEC;
         ST_EXEC:   state_nx = ST_RESULT;
         ST_RESULT: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // State-decoded controls: handshake, issue strobe and commit strobe
   always_comb begin
      req_ready = 1'b0;
      issue     = 1'b0;
      commit    = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = !RESET;
            issue     = req_valid && cond_pass;
         end
         ST_RESULT: commit = 1'b1;
         default: ;
      endcase
   end

   // Latch the accepted op; alu_* double as the op latch and hold between issues
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         alu_src1        <= '0;
         alu_src2        <= '0;
         alu_cmd         <= '0;
         alu_shift_carry <= 1'b0;
         alu_was_shifted <= 1'b0;
         rd_q            <= '0;
         set_flags_q     <= 1'b0;
      end else if (issue) begin
         alu_src1        <= req_src1;
         alu_src2        <= req_src2;
         alu_cmd         <= req_cmd;
         alu_shift_carry <= req_shift_carry;
         alu_was_shifted <= req_was_shifted;
         rd_q            <= req_rd;
         set_flags_q     <= req_set_flags;
      end
   end

   // Merge ALU flags into NZCV: arithmetic takes all four, logical keeps V and keeps C unless shifted
   always_comb begin
      upd_flags = is_test(alu_cmd) || set_flags_q;
      do_wb     = !is_test(alu_cmd);
      flags_nx  = flags;
      if (is_arith(alu_cmd)) begin
         flags_nx = alu_nzcv;
      end else begin
         flags_nx[FLAG_N] = alu_nzcv[FLAG_N];
         flags_nx[FLAG_Z] = alu_nzcv[FLAG_Z];
         if (alu_was_shifted) begin
            flags_nx[FLAG_C] = alu_nzcv[FLAG_C];
         end
      end
   end

   // Commit in RESULT: register writeback and flags; a reset here drops the op
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         flags    <= '0;
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
      end else begin
         wb_valid <= 1'b0;
         if (commit) begin
            if (upd_flags) begin
               flags <= flags_nx;
            end
            if (do_wb) begin
               wb_valid <= 1'b1;
               wb_rd    <= rd_q;
               wb_data  <= alu_result;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural ALU and reference model
module tb_alu_sequencer;

   localparam int DATA_W = 32;
   localparam int RD_W   = 4;

   logic              CLOCK_50 = 1'b0;
   logic              RESET;
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_cond;
   logic [3:0]        req_cmd;
   logic              req_set_flags;
   logic [RD_W-1:0]   req_rd;
   logic [DATA_W-1:0] req_src1;
   logic [DATA_W-1:0] req_src2;
   logic              req_shift_carry;
   logic              req_was_shifted;
   logic [DATA_W-1:0] alu_src1;
   logic [DATA_W-1:0] alu_src2;
   logic [3:0]        alu_cmd;
   logic              alu_shift_carry;
   logic              alu_was_shifted;
   logic [3:0]        alu_flags;
   logic [DATA_W-1:0] alu_result;
   logic [3:0]        alu_nzcv;
   logic [3:0]        flags;
   logic              wb_valid;
   logic [RD_W-1:0]   wb_rd;
   logic [DATA_W-1:0] wb_data;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] m_flags;

   alu_sequencer #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
      .CLOCK_50        (CLOCK_50),
      .RESET           (RESET),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_cond        (req_cond),
      .req_cmd         (req_cmd),
      .req_set_flags   (req_set_flags),
      .req_rd          (req_rd),
      .req_src1        (req_src1),
      .req_src2        (req_src2),
      .req_shift_carry (req_shift_carry),
      .req_was_shifted (req_was_shifted),
      .alu_src1        (alu_src1),
      .alu_src2        (alu_src2),
      .alu_cmd         (alu_cmd),
      .alu_shift_carry (alu_shift_carry),
      .alu_was_shifted (alu_was_shifted),
      .alu_flags       (alu_flags),
      .alu_result      (alu_result),
      .alu_nzcv        (alu_nzcv),
      .flags           (flags),
      .wb_valid        (wb_valid),
      .wb_rd           (wb_rd),
      .wb_data         (wb_data)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // ARM data-processing semantics; returns {nzcv, result}
   function automatic logic [35:0] alu_fn(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] fl,
                                          input logic sc);
      logic [32:0] s;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] r;
      logic        cin;
      logic        arith;
      arith = 1'b1;
      x = a;
      y = b;
      cin = 1'b0;
      case (cmd)
         4'd2, 4'd10: begin y = ~b; cin = 1'b1; end
         4'd3:        begin x = b; y = ~a; cin = 1'b1; end
         4'd4, 4'd11: ;
         4'd5:        cin = fl[1];
         4'd6:        begin y = ~b; cin = fl[1]; end
         4'd7:        begin x = b; y = ~a; cin = fl[1]; end
         default:     arith = 1'b0;
      endcase
      if (arith) begin
         s = {1'b0, x} + {1'b0, y} + {32'd0, cin};
         r = s[31:0];
         return {r[31], r == 32'd0, s[32], (x[31] == y[31]) && (r[31] != x[31]), r};
      end
      case (cmd)
         4'd0, 4'd8: r = a & b;
         4'd1, 4'd9: r = a ^ b;
         4'd12:      r = a | b;
         4'd13:      r = b;
         4'd14:      r = a & ~b;
         default:    r = ~b;
      endcase
      // Logical ALU reports the shifter carry and a deliberately wrong V
      return {r[31], r == 32'd0, sc, ~fl[0], r};
   endfunction

`ifdef ALU_SEQ_CONDEXEC_EN
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
`endif

   // Registered ALU with one cycle of latency
   always_ff @(posedge CLOCK_50) begin
      {alu_nzcv, alu_result} <= alu_fn(alu_cmd, alu_src1, alu_src2, alu_flags, alu_shift_carry);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic drive_junk();
      req_cond        = 4'($urandom);
      req_cmd         = 4'($urandom);
      req_set_flags   = 1'($urandom);
      req_rd          = RD_W'($urandom);
      req_src1        = $urandom;
      req_src2        = $urandom;
      req_shift_carry = 1'($urandom);
      req_was_shifted = 1'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = 1'b0;
         drive_junk();
         tick();
         chk("idle_wb", wb_valid, 1'b0);
         chk("idle_ready", req_ready, 1'b1);
      end
   endtask

   // Offer one op in a ready cycle and follow it to completion against the model
   task automatic run_op(input logic [3:0] cond, input logic [3:0] cmd, input logic s,
                         input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input logic sc, input logic ws);
      logic        pass;
      logic        is_tst;
      logic        is_ar;
      logic [35:0] f;
      chk("ready_before", req_ready, 1'b1);
      chk("alu_flags", alu_flags, m_flags);
`ifdef ALU_SEQ_CONDEXEC_EN
      pass = cond_ok(cond, m_flags);
`else
      pass = 1'b1;
`endif
      req_cond = cond; req_cmd = cmd; req_set_flags = s; req_rd = rd;
      req_src1 = a; req_src2 = b; req_shift_carry = sc; req_was_shifted = ws;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      drive_junk();
      chk("wb_t1", wb_valid, 1'b0);
      if (!pass) begin
         chk("ready_after_fail", req_ready, 1'b1);
         chk("flags_after_fail", flags, m_flags);
         return;
      end
      chk("ready_exec", req_ready, 1'b0);
      chk("alu_src1", alu_src1, a);
      chk("alu_src2", alu_src2, b);
      chk("alu_cmd", alu_cmd, cmd);
      chk("alu_sc_ws", {alu_shift_carry, alu_was_shifted}, {sc, ws});
      f = alu_fn(cmd, a, b, m_flags, sc);
      tick();
      chk("wb_t2", wb_valid, 1'b0);
      chk("ready_result", req_ready, 1'b0);
      tick();
      is_tst = (cmd >= 4'd8) && (cmd <= 4'd11);
      is_ar  = ((cmd >= 4'd2) && (cmd <= 4'd7)) || (cmd == 4'd10) || (cmd == 4'd11);
      if (is_tst || s) begin
         if (is_ar) m_flags = f[35:32];
         else       m_flags = {f[31], f[31:0] == 32'd0, ws ? sc : m_flags[1], m_flags[0]};
      end
      chk("wb_valid", wb_valid, !is_tst);
      if (!is_tst) begin
         chk("wb_rd", wb_rd, rd);
         chk("wb_data", wb_data, f[31:0]);
      end
      chk("flags", flags, m_flags);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1;
      req_valid = 1'b0;
      drive_junk();
      m_flags = 4'b0000;
      tick(); tick(); tick();
      chk("rst_flags", flags, 4'b0000);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_rd", wb_rd, 4'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_alu_src1", alu_src1, 32'd0);
      chk("rst_alu_src2", alu_src2, 32'd0);
      chk("rst_alu_misc", {alu_cmd, alu_shift_carry, alu_was_shifted}, 6'd0);
      chk("rst_ready", req_ready, 1'b0);
      RESET = 1'b0;
      #1;
      chk("ready_after_rst", req_ready, 1'b1);

      // ADD overflow into the sign bit
      run_op(4'b1110, 4'b0100, 1'b1, 4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      chk("tp_add_wb", wb_valid, 1'b1);
      chk("tp_add_rd", wb_rd, 4'd3);
      chk("tp_add_data", wb_data, 32'h8000_0000);
      chk("tp_add_flags", flags, 4'b1001);

      // SUB to zero with and without S
      run_op(4'b1110, 4'b0010, 1'b1, 4'd1, 32'd5, 32'd5, 1'b0, 1'b0);
      chk("tp_sub_data", wb_data, 32'd0);
      chk("tp_sub_flags", flags, 4'b0110);
      run_op(4'b1110, 4'b0010, 1'b0, 4'd2, 32'd5, 32'd5, 1'b0, 1'b0);
      chk("tp_sub_nos_flags", flags, 4'b0110);

      // CMP then a conditional ADD (skipped when conditional execution is built in)
      run_op(4'b1110, 4'b1010, 1'b0, 4'd0, 32'd3, 32'd7, 1'b0, 1'b0);
      chk("tp_cmp_flags", flags, 4'b1000);
      chk("tp_cmp_nowb", wb_valid, 1'b0);
      run_op(4'b0000, 4'b0100, 1'b0, 4'd5, 32'd1, 32'd1, 1'b0, 1'b0);

      // Build flags=0001: SUB giving C,V then MOV with shifted carry 0
      run_op(4'b1110, 4'b0010, 1'b1, 4'd4, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
      chk("tp_subv_flags", flags, 4'b0011);
      run_op(4'b1110, 4'b1101, 1'b1, 4'd6, 32'd0, 32'd5, 1'b0, 1'b1);
      chk("tp_mov_flags", flags, 4'b0001);
      run_op(4'b1110, 4'b0000, 1'b1, 4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
      chk("tp_and_shifted", flags, 4'b1011);
      run_op(4'b1110, 4'b1101, 1'b1, 4'd6, 32'd0, 32'd5, 1'b0, 1'b1);
      run_op(4'b1110, 4'b0000, 1'b1, 4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      chk("tp_and_unshifted", flags, 4'b1001);

      // ADC uses the carry flag
      run_op(4'b1110, 4'b1010, 1'b0, 4'd0, 32'd5, 32'd5, 1'b0, 1'b0);
      run_op(4'b1110, 4'b0101, 1'b1, 4'd8, 32'd1, 32'd1, 1'b0, 1'b0);
      chk("tp_adc_data", wb_data, 32'd3);

      // RESET pulsed during EXEC of an ADD
      run_op(4'b1110, 4'b1010, 1'b0, 4'd0, 32'd3, 32'd7, 1'b0, 1'b0);
      req_cond = 4'b1110; req_cmd = 4'b0100; req_set_flags = 1'b1; req_rd = 4'd9;
      req_src1 = 32'd10; req_src2 = 32'd20; req_shift_carry = 1'b0; req_was_shifted = 1'b0;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      RESET = 1'b1;
      tick();
      chk("abort_flags", flags, 4'b0000);
      chk("abort_wb", wb_valid, 1'b0);
      RESET = 1'b0;
      m_flags = 4'b0000;
      #1;
      chk("abort_ready", req_ready, 1'b1);
      idle(3);

      // Randomised ops with random gaps
      for (int k = 0; k < 300; k++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 3))
            0: a = 32'h8000_0000;
            1: b = a;
            2: begin a = a & 32'hF; b = b & 32'hF; end
            default: ;
         endcase
         run_op(4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), a, b,
                1'($urandom), 1'($urandom));
         idle(int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue controller and flag-register owner for the registered ALU. Accepts one decoded data-processing op at a time over a valid/ready handshake and evaluates its ARM-style condition code against the architectural NZCV register. It drives the ALU operand/command inputs, waits out the ALU's one-cycle latency, then commits the result to register-file writeback and merges ALU flags into NZCV. It sits between decode and the ALU/register file.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- RD_W, 4, destination register index width

Ports:
- CLOCK_50  in  1  clock
- RESET  in  1  synchronous, active-high reset
- req_valid  in  1  op offered
- req_ready  out  1  high in IDLE when RESET is low
- req_cond  in  4  condition field
- req_cmd  in  4  ALU command, same encoding as the ALU
- req_set_flags  in  1  S bit
- req_rd  in  RD_W  destination register
- req_src1, req_src2  in  DATA_W  operands; src2 is already shifted
- req_shift_carry, req_was_shifted  in  1  shifter carry-out and shift-used flag
- alu_src1, alu_src2  out  DATA_W  to ALU
- alu_cmd  out  4  to ALU
- alu_shift_carry, alu_was_shifted  out  1  to ALU
- alu_flags  out  4  to ALU; always equals flags
- alu_result  in  DATA_W  ALU output
- alu_nzcv  in  4  ALU flags
- flags  out  4  architectural NZCV, order [3]=N [2]=Z [1]=C [0]=V
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  RD_W  writeback register
- wb_data  out  DATA_W  writeback data

## Operation
- States:
  - IDLE: accept on req_valid&&req_ready and latch all req_* fields.
    - Condition passes: go to EXEC.
    - Condition fails: consume the op, stay in IDLE, no ALU or flag activity.
  - EXEC → RESULT unconditionally.
  - RESULT → IDLE unconditionally.
- Condition evaluation uses the current flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - 1110 always; 1111 never
- EXEC: alu_* driven from the latched fields. alu_* hold their last values in every other state.
- RESULT: sample alu_result and alu_nzcv.
- Commands 1000–1011 (TST, TEQ, CMP, CMN):
  - No writeback.
  - Flags always updated, regardless of req_set_flags.
- All other commands:
  - Writeback of alu_result to the latched rd.
  - Flags updated only if req_set_flags.
- Flag merge when updating:
  - Arithmetic (0010–0111, 1010, 1011): all four bits from alu_nzcv.
  - Logical/move (0000, 0001, 1000, 1001, 1100–1111): N and Z from alu_nzcv.
    - C from alu_nzcv[1] if the latched was_shifted is 1, else C is kept.
    - V is always kept.
- Reset values: flags=0000, wb_valid=0, wb_rd=0, wb_data=0, all alu_* outputs=0, state IDLE.
- RESET asserted in EXEC or RESULT aborts the op: no writeback, no flag update.

## Timing
- Accept at cycle T. EXEC is T+1. ALU registers its output at the end of T+1.
- RESULT is T+2. At the end of T+2, flags, wb_data and wb_rd are registered.
- wb_valid is high for exactly cycle T+3. Updated flags are visible from T+3.
- req_ready is high again at T+3. Peak throughput is one executed op per 3 cycles.
- A condition-failed op occupies one cycle. The next op can be accepted at T+1.
- req_valid may drop without acceptance. Inputs need to be stable only in the accept cycle.

## Configuration
- ALU_SEQ_CONDEXEC_EN defined: condition evaluation exactly as described above.
- ALU_SEQ_CONDEXEC_EN undefined:
  - req_cond is ignored and every op executes (treated as 1110).
  - The condition evaluator is not instantiated.

## Structure
- Package alu_seq_pkg holds:
  - ALU command enum (4-bit), condition enum (4-bit) and state enum.
  - Functions is_arith(cmd) and is_test(cmd) (true for 1000–1011).
  - NZCV bit-index constants.
- One sub-module, cond_check: purely combinational, inputs cond[3:0] and nzcv[3:0], output pass.
  - Instantiated only under ALU_SEQ_CONDEXEC_EN.

## Test plan
- flags=0000; ADD (0100) 0x7FFFFFFF+0x00000001, S=1, rd=3, cond=1110
  - → wb_valid at T+3 with wb_rd=3, wb_data=0x80000000; flags=1001.
- SUB (0010) 5−5, S=1 → wb_data=0, flags=0110. Repeat with S=0 → flags unchanged.
- CMP (1010) 3 vs 7, then ADD with cond=EQ
  - → flags=1000, CMP has no wb_valid.
  - ADD is consumed in one cycle, never asserts wb_valid, and the next op is accepted the following cycle.
- flags=0001; AND (0000) 0x80000000 & 0xFFFFFFFF, S=1, was_shifted=1, shift_carry=1 → flags=1011 (V kept). Same op with was_shifted=0 → flags=1001.
- flags C=1; ADC (0101) 1+1, S=1 → wb_data=3.
- RESET pulsed during EXEC of an ADD → no wb_valid, flags=0000, req_ready=1 in the first cycle after RESET drops.
